// File: rtl/hwpe_kernel_adapter_multi_pkg.sv
// Shared types and default widths for the multi-stream HWPE kernel adapter.
package hwpe_kernel_adapter_multi_package;

  localparam int unsigned DEFAULT_N_IN   = 2;
  localparam int unsigned DEFAULT_N_OUT  = 2;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic                     start;
    logic                     clear;
    logic [DEFAULT_CNT_W-1:0] n_tiles;
  } ctrl_kernel_adapter_multi_t;

  typedef struct packed {
    logic                     ready;
    logic                     done;
    logic                     idle;
    logic [DEFAULT_CNT_W-1:0] tile_cnt;
  } flags_kernel_adapter_multi_t;

endpackage

// File: rtl/hwpe_kernel_adapter_multi_quota_counter.sv
// Per-stream handshake counter: wraps at quota-1 and latches a met bit that
// survives until the group-wide fire consumes it.
module hwpe_quota_counter
  import hwpe_kernel_adapter_multi_package::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_quota,
  input  logic             i_hs,
  input  logic             i_fire,
  output logic             o_met
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic             r_met;
  logic             w_wrap;

  assign w_wrap = i_hs && (r_cnt == r_last);
  assign o_met  = r_met;

  // Count handshakes, capture the quota at job start; a wrap in the fire cycle is kept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_last <= '0;
      r_met  <= 1'b0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_met <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_met  <= 1'b0;
      r_last <= (i_quota == '0) ? '0 : i_quota - CNT_W'(1);
    end else begin
      if (i_hs) begin
        r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end
      r_met <= (i_fire ? 1'b0 : r_met) | w_wrap;
    end
  end

endmodule

// File: rtl/hwpe_kernel_adapter_multi.sv
// Adapter between the HWPE streamer and an HLS kernel with N_IN/N_OUT streams.
// Inputs are only accepted while a job runs; outputs always drain to the streamer.
//
//   state | meaning
//   IDLE  | no job; inputs blocked, idle_o high, waiting for start_i
//   RUN   | job active; counting handshakes, emitting ready/done per tile
module hwpe_kernel_adapter_multi
  import hwpe_kernel_adapter_multi_package::*;
#(
  parameter int unsigned N_IN   = DEFAULT_N_IN,
  parameter int unsigned N_OUT  = DEFAULT_N_OUT,
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    test_mode_i,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic [N_IN*CNT_W-1:0]   in_quota_i,
  input  logic [N_OUT*CNT_W-1:0]  out_quota_i,
  input  logic [CNT_W-1:0]        n_tiles_i,
  input  logic [N_IN*DATA_W-1:0]  in_data_i,
  input  logic [N_IN-1:0]         in_valid_i,
  output logic [N_IN-1:0]         in_ready_o,
  output logic [N_OUT*DATA_W-1:0] out_data_o,
  output logic [N_OUT-1:0]        out_valid_o,
  input  logic [N_OUT-1:0]        out_ready_i,
  output logic [N_IN*DATA_W-1:0]  k_in_tdata_o,
  output logic [N_IN-1:0]         k_in_tvalid_o,
  input  logic [N_IN-1:0]         k_in_tready_i,
  input  logic [N_OUT*DATA_W-1:0] k_out_tdata_i,
  input  logic [N_OUT-1:0]        k_out_tvalid_i,
  output logic [N_OUT-1:0]        k_out_tready_o,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    idle_o,
  output logic [CNT_W-1:0]        tile_cnt_o
);

  state_t           r_state;
  logic [CNT_W-1:0] r_tile;
  logic [CNT_W-1:0] r_tile_last;

  logic             w_run;
  logic             w_start_acc;
  logic [N_IN-1:0]  w_hs_in;
  logic [N_OUT-1:0] w_hs_out;
  logic [N_IN-1:0]  w_met_in;
  logic [N_OUT-1:0] w_met_out;
  logic             w_fire_in;
  logic             w_fire_out;
  logic             w_unused;

  assign w_unused    = test_mode_i;
  assign w_run       = (r_state == RUN);
  assign w_start_acc = start_i && !clear_i && !w_run;

  assign k_in_tdata_o   = in_data_i;
  assign k_in_tvalid_o  = in_valid_i & {N_IN{w_run}};
  assign in_ready_o     = k_in_tready_i & {N_IN{w_run}};
  assign w_hs_in        = in_valid_i & in_ready_o;

  assign out_data_o     = k_out_tdata_i;
  assign out_valid_o    = k_out_tvalid_i;
  assign k_out_tready_o = out_ready_i;
  assign w_hs_out       = k_out_tvalid_i & out_ready_i & {N_OUT{w_run}};

  assign w_fire_in  = &w_met_in;
  assign w_fire_out = &w_met_out;
  assign ready_o    = w_fire_in && w_run;
  assign done_o     = w_fire_out && w_run;
  assign idle_o     = !w_run;
  assign tile_cnt_o = r_tile;

  for (genvar gi = 0; gi < N_IN; gi++) begin : g_in_cnt
    hwpe_quota_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clear (clear_i),
      .i_load  (w_start_acc),
      .i_quota (in_quota_i[gi*CNT_W +: CNT_W]),
      .i_hs    (w_hs_in[gi]),
      .i_fire  (w_fire_in),
      .o_met   (w_met_in[gi])
    );
  end

  for (genvar go = 0; go < N_OUT; go++) begin : g_out_cnt
    hwpe_quota_counter #(.CNT_W(CNT_W)) u_cnt (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_clear (clear_i),
      .i_load  (w_start_acc),
      .i_quota (out_quota_i[go*CNT_W +: CNT_W]),
      .i_hs    (w_hs_out[go]),
      .i_fire  (w_fire_out),
      .o_met   (w_met_out[go])
    );
  end

  // Job FSM and tile counter; the last done of a job returns to IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_tile      <= '0;
      r_tile_last <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_tile  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state     <= RUN;
            r_tile      <= '0;
            r_tile_last <= (n_tiles_i == '0) ? '0 : n_tiles_i - CNT_W'(1);
          end
        end
        RUN: begin
          if (done_o) begin
            if (r_tile == r_tile_last) begin
              r_tile  <= '0;
              r_state <= IDLE;
            end else begin
              r_tile <= r_tile + CNT_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_kernel_adapter_multi.sv
// Bench for hwpe_kernel_adapter_multi: directed scenarios plus a random phase,
// all compared every cycle against a job/quota model kept in the bench.
module tb_hwpe_kernel_adapter_multi;

  localparam int NI = 2;
  localparam int NO = 2;
  localparam int DW = 32;
  localparam int CW = 16;

  logic clk;
  logic rst_n, test_mode, start, clear;
  logic [NI*CW-1:0] in_quota;
  logic [NO*CW-1:0] out_quota;
  logic [CW-1:0]    n_tiles;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]    in_valid, in_ready_o, k_in_tvalid_o, k_in_tready;
  logic [NI*DW-1:0] k_in_tdata_o;
  logic [NO*DW-1:0] out_data_o, k_out_tdata;
  logic [NO-1:0]    out_valid_o, out_ready, k_out_tvalid, k_out_tready_o;
  logic             ready_o, done_o, idle_o;
  logic [CW-1:0]    tile_cnt_o;

  hwpe_kernel_adapter_multi #(.N_IN(NI), .N_OUT(NO), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .start_i(start), .clear_i(clear),
    .in_quota_i(in_quota), .out_quota_i(out_quota), .n_tiles_i(n_tiles),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .k_in_tdata_o(k_in_tdata_o), .k_in_tvalid_o(k_in_tvalid_o), .k_in_tready_i(k_in_tready),
    .k_out_tdata_i(k_out_tdata), .k_out_tvalid_i(k_out_tvalid), .k_out_tready_o(k_out_tready_o),
    .ready_o(ready_o), .done_o(done_o), .idle_o(idle_o), .tile_cnt_o(tile_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int n_rdy    = 0;
  int n_done   = 0;
  int tile_sum = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: job phase, per-stream progress within the current group, pending-group flags.
  bit m_valid = 0;
  bit m_run   = 0;
  int m_iq[NI], m_oq[NO], m_icnt[NI], m_ocnt[NO];
  bit m_ipend[NI], m_opend[NO];
  int m_nt, m_tiles;
  bit p_ready, p_done, p_idle;
  int p_tile;

  function automatic int eff(input logic [CW-1:0] q);
    return (q == 0) ? 1 : int'(q);
  endfunction

  task model_step();
    bit all_i, all_o, hs, wr;
    if (!rst_n || clear) begin
      if (!rst_n) m_valid = 1;
      m_run = 0; m_tiles = 0;
      for (int i = 0; i < NI; i++) begin m_icnt[i] = 0; m_ipend[i] = 0; end
      for (int o = 0; o < NO; o++) begin m_ocnt[o] = 0; m_opend[o] = 0; end
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_tiles = 0; m_nt = eff(n_tiles);
        for (int i = 0; i < NI; i++) begin
          m_iq[i] = eff(in_quota[i*CW +: CW]); m_icnt[i] = 0; m_ipend[i] = 0;
        end
        for (int o = 0; o < NO; o++) begin
          m_oq[o] = eff(out_quota[o*CW +: CW]); m_ocnt[o] = 0; m_opend[o] = 0;
        end
      end
    end else begin
      all_i = 1; all_o = 1;
      for (int i = 0; i < NI; i++) all_i &= m_ipend[i];
      for (int o = 0; o < NO; o++) all_o &= m_opend[o];
      for (int i = 0; i < NI; i++) begin
        hs = in_valid[i] & k_in_tready[i];
        wr = hs && (m_icnt[i] == m_iq[i] - 1);
        if (hs) m_icnt[i] = wr ? 0 : m_icnt[i] + 1;
        m_ipend[i] = (all_i ? 1'b0 : m_ipend[i]) | wr;
      end
      for (int o = 0; o < NO; o++) begin
        hs = k_out_tvalid[o] & out_ready[o];
        wr = hs && (m_ocnt[o] == m_oq[o] - 1);
        if (hs) m_ocnt[o] = wr ? 0 : m_ocnt[o] + 1;
        m_opend[o] = (all_o ? 1'b0 : m_opend[o]) | wr;
      end
      if (all_o) begin
        if (m_tiles == m_nt - 1) begin m_run = 0; m_tiles = 0; end
        else m_tiles++;
      end
    end
    all_i = 1; all_o = 1;
    for (int i = 0; i < NI; i++) all_i &= m_ipend[i];
    for (int o = 0; o < NO; o++) all_o &= m_opend[o];
    p_ready = m_run & all_i;
    p_done  = m_run & all_o;
    p_idle  = !m_run;
    p_tile  = m_tiles;
  endtask

  // Compare process: checks all outputs mid-cycle, then advances the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ready_o", ready_o, p_ready);
      chk("done_o", done_o, p_done);
      chk("idle_o", idle_o, p_idle);
      chk("tile_cnt_o", tile_cnt_o, p_tile[CW-1:0]);
      chk("in_ready_o", in_ready_o, k_in_tready & {NI{m_run}});
      chk("k_in_tvalid_o", k_in_tvalid_o, in_valid & {NI{m_run}});
      chk("k_in_tdata_o", k_in_tdata_o, in_data);
      chk("out_valid_o", out_valid_o, k_out_tvalid);
      chk("out_data_o", out_data_o, k_out_tdata);
      chk("k_out_tready_o", k_out_tready_o, out_ready);
      if (ready_o) n_rdy++;
      if (done_o) begin n_done++; tile_sum += int'(tile_cnt_o); end
    end
    model_step();
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic begin_job(input logic [CW-1:0] iq0, iq1, oq0, oq1, nt);
    in_quota = {iq1, iq0}; out_quota = {oq1, oq0}; n_tiles = nt;
    start = 1; cyc(); start = 0;
  endtask

  int d0, s0, r0;

  initial begin
    rst_n = 0; test_mode = 0; start = 0; clear = 0;
    in_quota = '0; out_quota = '0; n_tiles = '0;
    in_data = 64'h1111_2222_3333_4444; in_valid = '0; k_in_tready = '0;
    k_out_tdata = 64'hAAAA_5555_0F0F_F0F0; k_out_tvalid = '0; out_ready = '0;
    cyc(2);
    rst_n = 1;

    // 1: no start, inputs must stay blocked
    in_valid = 2'b11; k_in_tready = 2'b11;
    cyc(3);
    chk("t1_in_ready", in_ready_o, 2'b00);
    chk("t1_idle", idle_o, 1'b1);
    chk("t1_ready_done", {ready_o, done_o}, 2'b00);
    in_valid = 0; k_in_tready = 0;

    // 2: unit quotas, four tiles
    begin_job(1, 1, 1, 1, 4);
    d0 = n_done; s0 = tile_sum;
    for (int t = 0; t < 4; t++) begin
      in_valid = 2'b11; k_in_tready = 2'b11; cyc();
      in_valid = 0; k_out_tvalid = 2'b11; out_ready = 2'b11; cyc();
      k_out_tvalid = 0; cyc();
    end
    chk("t2_done_count", n_done - d0, 4);
    chk("t2_tile_sum", tile_sum - s0, 6);
    chk("t2_idle", idle_o, 1'b1);
    chk("t2_tile_cnt", tile_cnt_o, 0);

    // 3: unequal output quotas, out0=10 out1=1
    begin_job(1, 1, 10, 1, 1);
    d0 = n_done;
    k_out_tvalid = 2'b10; cyc();
    k_out_tvalid = 2'b01; cyc(9);
    k_out_tvalid = 0; cyc(2);
    chk("t3_no_early_done", n_done - d0, 0);
    k_out_tvalid = 2'b01; cyc();
    k_out_tvalid = 0;
    chk("t3_done_after_10th", done_o, 1'b1);
    cyc();
    chk("t3_idle", idle_o, 1'b1);
    chk("t3_done_count", n_done - d0, 1);

    // 4: in quota 1, back-to-back inputs
    begin_job(1, 1, 5, 5, 1);
    r0 = n_rdy;
    in_valid = 2'b11; k_in_tready = 2'b11;
    cyc(20);
    in_valid = 0; cyc(2);
    chk("t4_ready_count", n_rdy - r0, 20);
    clear = 1; cyc(); clear = 0;
    chk("t4_idle_after_clear", idle_o, 1'b1);

    // 5: clear mid-tile after 3 of 5 outputs, then a fresh job needs all 5
    begin_job(1, 1, 5, 5, 1);
    k_out_tvalid = 2'b11; cyc(3);
    k_out_tvalid = 0; clear = 1; cyc(); clear = 0;
    chk("t5_idle_after_clear", idle_o, 1'b1);
    begin_job(1, 1, 5, 5, 1);
    d0 = n_done;
    k_out_tvalid = 2'b11; cyc(4);
    k_out_tvalid = 0; cyc(2);
    chk("t5_no_done_at_4", n_done - d0, 0);
    k_out_tvalid = 2'b11; cyc();
    k_out_tvalid = 0;
    chk("t5_done_at_5", done_o, 1'b1);
    cyc();
    chk("t5_idle", idle_o, 1'b1);

    // 6: reset during RUN with start held
    begin_job(3, 3, 3, 3, 2);
    k_out_tvalid = 2'b11; cyc(2); k_out_tvalid = 0;
    rst_n = 0; start = 1; cyc();
    rst_n = 1; start = 0;
    chk("t6_idle", idle_o, 1'b1);
    chk("t6_flags", {ready_o, done_o, tile_cnt_o}, 0);
    cyc();
    chk("t6_still_idle", idle_o, 1'b1);

    // Random phase: quotas and n_tiles change every cycle; only start samples them.
    for (int c = 0; c < 3000; c++) begin
      in_valid     = 2'($urandom);
      k_in_tready  = 2'($urandom);
      k_out_tvalid = 2'($urandom);
      out_ready    = 2'($urandom);
      in_data      = {$urandom, $urandom};
      k_out_tdata  = {$urandom, $urandom};
      in_quota     = {CW'($urandom_range(0, 4)), CW'($urandom_range(0, 4))};
      out_quota    = {CW'($urandom_range(0, 6)), CW'($urandom_range(0, 6))};
      n_tiles      = CW'($urandom_range(0, 3));
      start        = ($urandom_range(0, 7) == 0);
      clear        = ($urandom_range(0, 199) == 0);
      rst_n        = ($urandom_range(0, 499) != 0);
      test_mode    = 1'($urandom);
      cyc();
    end
    start = 0; clear = 0; rst_n = 1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
